avl_bus_arbiter: RTL and testbench
==================================

AVL_BUS_ARBITER -- requirements
Module: avl_bus_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 4, number of requesting masters (legal 1..32).
REQ-002 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 SHALL have parameter TIMEOUT, default 255, lock watchdog limit in cycles (legal 1..65535), used only under AVL_BUS_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  MASTER_NUM  per-master bus request, level.
REQ-007 SHALL have port done  input  1  one-cycle pulse from owner marking end of transaction/burst.
REQ-008 SHALL have port grant  output  MASTER_NUM  one-hot grant, registered.
REQ-009 SHALL have port grant_idx  output  IDXW  binary index of granted master, IDXW = max(1, clog2(MASTER_NUM)), registered.
REQ-010 SHALL have port grant_valid  output  1  high while any grant is held, registered.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse when watchdog forces release, registered.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and LOCKED (one owner).
REQ-013 In IDLE with req != 0 at a clock edge, SHALL enter LOCKED and present grant/grant_idx/grant_valid from that edge (1-cycle latency req -> grant).
REQ-014 In IDLE with req == 0, SHALL stay IDLE with grant = 0, grant_valid = 0, grant_idx holding last value.
REQ-015 ARB_MODE 0 SHALL select the lowest set index of req.
REQ-016 ARB_MODE 1 SHALL select the first set index searching upward from last_idx+1, wrapping MASTER_NUM-1 -> 0; last_idx updates to the winner on every grant.
REQ-017 grant SHALL always be one-hot or zero and equal 1 << grant_idx whenever grant_valid = 1.
REQ-018 In LOCKED, grant SHALL be held regardless of req changes, including owner deasserting req.
REQ-019 done = 1 in LOCKED SHALL return to IDLE at that edge, deasserting grant; new arbitration occurs at the following edge (one bubble cycle minimum between owners).
REQ-020 done in IDLE SHALL be ignored.
REQ-021 MASTER_NUM = 1 SHALL degenerate to grant = req-gated lock, grant_idx constant 0.

Reset
REQ-022 rst = 1 SHALL immediately force state IDLE, grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0, watchdog count = 0, last_idx = MASTER_NUM-1 (first round-robin search starts at index 0).
REQ-023 Reset asserted mid-lock SHALL drop grant without waiting for done; first grant after release follows REQ-013.

Configuration
REQ-024 Macro AVL_BUS_ARB_TIMEOUT_EN defined: SHALL count cycles in LOCKED (count cleared on entry); when count reaches TIMEOUT without done, SHALL return to IDLE at that edge and pulse timeout for one cycle; done and timeout on the same edge SHALL be treated as done (timeout stays 0).
REQ-025 Macro AVL_BUS_ARB_TIMEOUT_EN undefined: SHALL contain no counter, timeout tied 0, lock held indefinitely until done or reset; port list unchanged.

Verification
REQ-026 Reset, MASTER_NUM=4, ARB_MODE=1, req=4'b1111 held, done pulsed each lock -> grant sequence 0001, 0010, 0100, 1000, 0001 with one idle cycle between each.
REQ-027 ARB_MODE=0, req=4'b1010 held, done pulsed each lock -> grant always 0010, grant_idx = 1.
REQ-028 Grant to master 2, then req drops to 0 for 10 cycles without done -> grant stays 0100, grant_valid = 1 throughout.
REQ-029 TIMEOUT_EN defined, TIMEOUT=8, lock master 0, no done -> release after 8 LOCKED cycles, timeout high exactly one cycle, then master 1 granted if req=4'b0011.
REQ-030 rst asserted asynchronously mid-lock (between edges) -> grant = 0 and grant_valid = 0 immediately; after release with req=4'b1000, first grant = 1000, grant_idx = 3.

Source files
------------

// File: rtl/avl_bus_arbiter.sv
// Single-owner bus arbiter: fixed-priority or round-robin selection, grant held until done.
// Optional lock watchdog enabled by defining AVL_BUS_ARB_TIMEOUT_EN.
module avl_bus_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int ARB_MODE   = 1,
  parameter int TIMEOUT    = 255,
  localparam int IDXW      = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] req,
  input  logic                  done,
  output logic [MASTER_NUM-1:0] grant,
  output logic [IDXW-1:0]       grant_idx,
  output logic                  grant_valid,
  output logic                  timeout
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [IDXW-1:0]       grant_idx_q, grant_idx_d;
  logic [IDXW-1:0]       last_idx_q, last_idx_d;
  logic [IDXW-1:0]       win_idx;
  logic [IDXW-1:0]       cand;
  logic                  win_found;

`ifdef AVL_BUS_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // Loops run from the far end so the last assignment is the winning candidate.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    if (ARB_MODE == 0) begin
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_idx   = IDXW'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int off = MASTER_NUM; off >= 1; off--) begin
        cand = IDXW'((int'(last_idx_q) + off) % MASTER_NUM);
        if (req[cand]) begin
          win_idx   = cand;
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
`ifdef AVL_BUS_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef AVL_BUS_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (win_found) begin
          state_d     = ST_LOCKED;
          grant_d     = MASTER_NUM'(1) << win_idx;
          grant_idx_d = win_idx;
          last_idx_d  = win_idx;
        end
      end
      ST_LOCKED: begin
        if (done) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
`ifdef AVL_BUS_ARB_TIMEOUT_EN
        // Count equals TIMEOUT-1 on the edge that closes the TIMEOUT-th locked cycle.
        else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_idx_q  <= IDXW'(MASTER_NUM - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
    end
  end

`ifdef AVL_BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with shared stimulus and
// compares both against an ownership-level reference model.
module tb_avl_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
`ifdef AVL_BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;

  logic [N-1:0] g_rr, g_fp;
  logic [1:0]   i_rr, i_fp;
  logic         v_rr, v_fp, t_rr, t_fp;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per unit: 0 = round-robin, 1 = fixed priority.
  int m_owner[2];
  int m_idx[2];
  int m_last[2];
  int m_held[2];
  bit m_to[2];

  always #5 clk = ~clk;

  avl_bus_arbiter #(.MASTER_NUM(N), .ARB_MODE(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(g_rr), .grant_idx(i_rr), .grant_valid(v_rr), .timeout(t_rr)
  );

  avl_bus_arbiter #(.MASTER_NUM(N), .ARB_MODE(0), .TIMEOUT(TO)) u_fp (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(g_fp), .grant_idx(i_fp), .grant_valid(v_fp), .timeout(t_fp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1;
      m_idx[u]   = 0;
      m_last[u]  = N - 1;
      m_held[u]  = 0;
      m_to[u]    = 1'b0;
    end
  endtask

  function automatic int pick(input int u, input logic [N-1:0] r);
    if (u == 1) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (r[(m_last[0] + k) % N]) return (m_last[0] + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic d, input logic rs);
    int w;
    if (rs) begin
      model_reset();
      return;
    end
    for (int u = 0; u < 2; u++) begin
      m_to[u] = 1'b0;
      if (m_owner[u] >= 0) begin
        if (d) m_owner[u] = -1;
        else if (TO_EN && m_held[u] == TO) begin
          m_owner[u] = -1;
          m_to[u]    = 1'b1;
        end else m_held[u]++;
      end else if (r != '0) begin
        w          = pick(u, r);
        m_owner[u] = w;
        m_idx[u]   = w;
        m_last[u]  = w;
        m_held[u]  = 1;
      end
    end
  endtask

  task automatic compare();
    logic [3:0] eg_rr, eg_fp;
    eg_rr = (m_owner[0] >= 0) ? 4'(1 << m_owner[0]) : 4'b0;
    eg_fp = (m_owner[1] >= 0) ? 4'(1 << m_owner[1]) : 4'b0;
    check("rr_grant", 32'(g_rr), 32'(eg_rr));
    check("rr_idx",   32'(i_rr), 32'(m_idx[0]));
    check("rr_valid", 32'(v_rr), 32'(m_owner[0] >= 0));
    check("rr_tmo",   32'(t_rr), 32'(m_to[0]));
    check("fp_grant", 32'(g_fp), 32'(eg_fp));
    check("fp_idx",   32'(i_fp), 32'(m_idx[1]));
    check("fp_valid", 32'(v_fp), 32'(m_owner[1] >= 0));
    check("fp_tmo",   32'(t_fp), 32'(m_to[1]));
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic d, input logic rs);
    @(negedge clk);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
    compare();
  endtask

  initial begin
    logic [3:0] seq [5];
    int k;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    model_reset();
    cycle(4'hf, 1'b0, 1'b1);

    // Round-robin rotation with all masters requesting, done on every lock.
    k = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(4'hf, m_owner[0] >= 0, 1'b0);
      if (m_owner[0] >= 0 && k < 5) begin
        check("rr_seq", 32'(g_rr), 32'(seq[k]));
        k++;
      end
    end

    // Fixed priority keeps picking master 1 out of 4'b1010.
    cycle(4'b1010, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      cycle(4'b1010, m_owner[1] >= 0, 1'b0);
      if (m_owner[1] >= 0) check("fp_1010", 32'(i_fp), 32'd1);
    end

    // Grant held after the owner withdraws its request.
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      if (!TO_EN) check("hold_0100", 32'(g_rr), 32'h4);
    end
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    // Asynchronous reset between edges while locked.
    cycle(4'b0001, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rr_grant", 32'(g_rr), 32'h0);
    check("async_rr_valid", 32'(v_rr), 32'h0);
    check("async_fp_grant", 32'(g_fp), 32'h0);
    model_reset();
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b0);
    check("post_rst_grant", 32'(g_rr), 32'h8);
    check("post_rst_idx",   32'(i_rr), 32'd3);

    // Watchdog: lock master 0, no done, then master 1 should follow.
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    for (int c = 0; c < 14; c++) cycle(c == 0 ? 4'b0001 : 4'b0011, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);

    for (int c = 0; c < 600; c++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
